// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//
// Sequential master for the register file's write port and its debug read
// port. A command is either a single-register write or a full dump. A dump
// walks every register address in ascending order and streams one
// (address, data) pair per word over a valid/ready output channel.
//
// Ports
//   clk, rst              clock (posedge) and asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0 = write register, 1 = dump all registers
//   cmd_addr, cmd_data    write target and value
//   rf_wa, rf_wd, rf_we   register file write port (registered)
//   rf_ra, rf_rd          register file debug read port (rf_rd is combinational)
//   out_valid/out_ready   dump word handshake
//   out_addr, out_data    dumped address and value (registered)
//   busy                  high in every state other than IDLE
// ---------------------------------------------------------------------------
module regfile_access_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_N-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [ADDR_N-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              rf_we,
   output logic [ADDR_N-1:0] rf_ra,
   input  logic [DATA_W-1:0] rf_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_N-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WRITE, SCAN, OUT} state_t;

   // The scan index carries one extra bit so that the last-address compare
   // and the increment never wrap inside the index itself.
   localparam logic [ADDR_N:0] LAST_IDX = {1'b0, {ADDR_N{1'b1}}};

   state_t            state_q, state_d;
   logic [ADDR_N:0]   idx_q, idx_d;
   logic [ADDR_N:0]   idxInc;
   logic [ADDR_N-1:0] rfWa_q, rfWa_d;
   logic [DATA_W-1:0] rfWd_q, rfWd_d;
   logic              rfWe_q, rfWe_d;
   logic [ADDR_N-1:0] rfRa_q, rfRa_d;
   logic              outValid_q, outValid_d;
   logic [ADDR_N-1:0] outAddr_q, outAddr_d;
   logic [DATA_W-1:0] outData_q, outData_d;

   assign idxInc = idx_q + 1'b1;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. WRITE always lasts one cycle; a dump alternates
   // SCAN (read address settles) and OUT (word waits for the consumer).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = cmd_op ? SCAN : WRITE;
            end
         end
         WRITE: state_d = IDLE;
         SCAN:  state_d = OUT;
         OUT: begin
            if (out_ready) begin
               state_d = (idx_q == LAST_IDX) ? IDLE : SCAN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Decoded outputs: only the command handshake and busy flag come
   // straight from the state, everything else is registered below.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
   end

   // Datapath next values. rf_we is only ever raised from IDLE, so it can
   // never be high while a dump is reading the register file.
   always_comb begin
      idx_d      = idx_q;
      rfWa_d     = rfWa_q;
      rfWd_d     = rfWd_q;
      rfWe_d     = rfWe_q;
      rfRa_d     = rfRa_q;
      outValid_d = outValid_q;
      outAddr_d  = outAddr_q;
      outData_d  = outData_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && !cmd_op) begin
               rfWa_d = cmd_addr;
               rfWd_d = cmd_data;
               rfWe_d = 1'b1;
            end else if (cmd_valid && cmd_op) begin
               idx_d  = '0;
               rfRa_d = '0;
            end
         end
         WRITE: begin
            rfWe_d = 1'b0;
         end
         SCAN: begin
            outData_d  = rf_rd;
            outAddr_d  = idx_q[ADDR_N-1:0];
            outValid_d = 1'b1;
         end
         OUT: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               if (idx_q != LAST_IDX) begin
                  idx_d  = idxInc;
                  rfRa_d = idxInc[ADDR_N-1:0];
               end
            end
         end
         default: begin
            rfWe_d     = 1'b0;
            outValid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers; reset abandons any write or partial dump.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q      <= '0;
         rfWa_q     <= '0;
         rfWd_q     <= '0;
         rfWe_q     <= 1'b0;
         rfRa_q     <= '0;
         outValid_q <= 1'b0;
         outAddr_q  <= '0;
         outData_q  <= '0;
      end else begin
         idx_q      <= idx_d;
         rfWa_q     <= rfWa_d;
         rfWd_q     <= rfWd_d;
         rfWe_q     <= rfWe_d;
         rfRa_q     <= rfRa_d;
         outValid_q <= outValid_d;
         outAddr_q  <= outAddr_d;
         outData_q  <= outData_d;
      end
   end

   assign rf_wa     = rfWa_q;
   assign rf_wd     = rfWd_q;
   assign rf_we     = rfWe_q;
   assign rf_ra     = rfRa_q;
   assign out_valid = outValid_q;
   assign out_addr  = outAddr_q;
   assign out_data  = outData_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_ctrl
//
// Drives two controllers (ADDR_N=3 and ADDR_N=2), each attached to a small
// behavioural register file. A reference array per instance records what
// every register should hold after the commands issued so far; dump words
// are compared against it. 'sel' picks which instance the shared stimulus
// and observation signals refer to.
// ---------------------------------------------------------------------------
module tb_regfile_access_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic sel;
   logic memClr;
   logic cmdValid, cmdOp, outReady;
   logic [2:0] cmdAddr;
   logic [3:0] cmdData;

   logic mCmdValid, mOutReady, mCmdReady, mRfWe, mOutValid, mBusy;
   logic [2:0] mRfWa, mRfRa, mOutAddr;
   logic [3:0] mRfWd, mRfRd, mOutData;

   logic sCmdValid, sOutReady, sCmdReady, sRfWe, sOutValid, sBusy;
   logic [1:0] sRfWa, sRfRa, sOutAddr;
   logic [3:0] sRfWd, sRfRd, sOutData;

   logic [3:0] memM [8];
   logic [3:0] memS [4];
   logic [3:0] expM [8];
   logic [3:0] expS [4];

   logic [31:0] obsReady, obsBusy, obsWe, obsWa, obsWd, obsRa;
   logic [31:0] obsValid, obsAddr, obsData;

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;
   bit ab;

   always #5 clk = ~clk;

   assign mCmdValid = cmdValid & ~sel;
   assign sCmdValid = cmdValid & sel;
   assign mOutReady = outReady & ~sel;
   assign sOutReady = outReady & sel;

   regfile_access_ctrl #(.DATA_W(4), .ADDR_N(3)) dutMain (
      .clk(clk), .rst(rst),
      .cmd_valid(mCmdValid), .cmd_ready(mCmdReady), .cmd_op(cmdOp),
      .cmd_addr(cmdAddr), .cmd_data(cmdData),
      .rf_wa(mRfWa), .rf_wd(mRfWd), .rf_we(mRfWe),
      .rf_ra(mRfRa), .rf_rd(mRfRd),
      .out_valid(mOutValid), .out_ready(mOutReady),
      .out_addr(mOutAddr), .out_data(mOutData), .busy(mBusy)
   );

   regfile_access_ctrl #(.DATA_W(4), .ADDR_N(2)) dutSmall (
      .clk(clk), .rst(rst),
      .cmd_valid(sCmdValid), .cmd_ready(sCmdReady), .cmd_op(cmdOp),
      .cmd_addr(cmdAddr[1:0]), .cmd_data(cmdData),
      .rf_wa(sRfWa), .rf_wd(sRfWd), .rf_we(sRfWe),
      .rf_ra(sRfRa), .rf_rd(sRfRd),
      .out_valid(sOutValid), .out_ready(sOutReady),
      .out_addr(sOutAddr), .out_data(sOutData), .busy(sBusy)
   );

   // Register files commit on the falling edge inside the rf_we period.
   always @(negedge clk) begin
      if (memClr) begin
         for (int i = 0; i < 8; i++) memM[i] <= 4'h0;
      end else if (mRfWe) begin
         memM[mRfWa] <= mRfWd;
      end
   end

   always @(negedge clk) begin
      if (memClr) begin
         for (int i = 0; i < 4; i++) memS[i] <= 4'h0;
      end else if (sRfWe) begin
         memS[sRfWa] <= sRfWd;
      end
   end

   assign mRfRd = memM[mRfRa];
   assign sRfRd = memS[sRfRa];

   assign obsReady = sel ? 32'(sCmdReady) : 32'(mCmdReady);
   assign obsBusy  = sel ? 32'(sBusy)     : 32'(mBusy);
   assign obsWe    = sel ? 32'(sRfWe)     : 32'(mRfWe);
   assign obsWa    = sel ? 32'(sRfWa)     : 32'(mRfWa);
   assign obsWd    = sel ? 32'(sRfWd)     : 32'(mRfWd);
   assign obsRa    = sel ? 32'(sRfRa)     : 32'(mRfRa);
   assign obsValid = sel ? 32'(sOutValid) : 32'(mOutValid);
   assign obsAddr  = sel ? 32'(sOutAddr)  : 32'(mOutAddr);
   assign obsData  = sel ? 32'(sOutData)  : 32'(mOutData);

   // Safety net in case a handshake never completes.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

   function automatic int depth();
      return sel ? 4 : 8;
   endfunction

   function automatic logic [31:0] expData(input int a);
      if (sel) return 32'(expS[a[1:0]]);
      return 32'(expM[a[2:0]]);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic op, input int a, input int d);
      cmdValid = v;
      cmdOp    = op;
      cmdAddr  = a[2:0];
      cmdData  = d[3:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady();
      int n = 0;
      while (obsReady == 0 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("readyWait", obsReady, 1);
   endtask

   // Single write: rf_we must be high for exactly one cycle with the
   // latched address/data, then the controller is ready again.
   task automatic doWrite(input int a, input int d);
      waitReady();
      applyStimulus(1'b1, 1'b0, a, d);
      tick();
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("wrWe", obsWe, 1);
      checkOutput("wrWa", obsWa, 32'(a));
      checkOutput("wrWd", obsWd, 32'(d));
      checkOutput("wrReadyLow", obsReady, 0);
      tick();
      checkOutput("wrWeDrop", obsWe, 0);
      checkOutput("wrReadyBack", obsReady, 1);
      if (sel) expS[a[1:0]] = d[3:0];
      else     expM[a[2:0]] = d[3:0];
   endtask

   // Full dump. Optionally stalls 5 cycles at stallAddr, uses random
   // backpressure, raises a write command while at rejAddr, or returns
   // right after the handshake of abortAt.
   task automatic doDump(input int stallAddr, input bit randBp, input int rejAddr,
                         input int abortAt, output bit aborted);
      int words = 0;
      int stall = 0;
      int cyc   = 0;
      bit held   = 0;
      bit weSeen = 0;
      aborted = 0;
      waitReady();
      applyStimulus(1'b1, 1'b1, 0, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("dumpBusy", obsBusy, 1);
      checkOutput("dumpRa0", obsRa, 0);
      outReady = 1'b0;
      while (words < depth() && cyc < 400) begin
         if (abortAt >= 0 && words == abortAt + 1) begin
            aborted = 1;
            break;
         end
         if (obsWe != 0) weSeen = 1;
         if (obsValid != 0) begin
            checkOutput("readyInOut", obsReady, 0);
            checkOutput("raIsIdx", obsRa, 32'(words));
            if (!held) begin
               checkOutput("outAddr", obsAddr, 32'(words));
               checkOutput("outData", obsData, expData(words));
               held = 1;
               if (words == stallAddr) stall = 5;
               if (words == rejAddr) applyStimulus(1'b1, 1'b0, 4, 3);
            end else begin
               checkOutput("holdAddr", obsAddr, 32'(words));
               checkOutput("holdData", obsData, expData(words));
            end
            if (stall > 0) begin
               outReady = 1'b0;
               stall--;
            end else begin
               outReady = randBp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (outReady) begin
               words++;
               held = 0;
            end
         end else begin
            outReady = randBp ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         tick();
         cyc++;
      end
      if (!aborted) begin
         checkOutput("dumpWords", 32'(words), 32'(depth()));
         checkOutput("dumpDoneBusy", obsBusy, 0);
         checkOutput("dumpDoneValid", obsValid, 0);
         checkOutput("dumpNoWe", 32'(weSeen), 0);
      end
      outReady = 1'b0;
   endtask

   initial begin
      int cnt;
      sel    = 1'b0;
      rst    = 1'b1;
      memClr = 1'b1;
      outReady = 1'b0;
      applyStimulus(1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 8; i++) expM[i] = 4'h0;
      for (int i = 0; i < 4; i++) expS[i] = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      memClr = 1'b0;

      // Reset values.
      checkOutput("rstReady", obsReady, 1);
      checkOutput("rstBusy", obsBusy, 0);
      checkOutput("rstWe", obsWe, 0);
      checkOutput("rstValid", obsValid, 0);
      checkOutput("rstWa", obsWa, 0);
      checkOutput("rstWd", obsWd, 0);
      checkOutput("rstRa", obsRa, 0);
      checkOutput("rstOutAddr", obsAddr, 0);
      checkOutput("rstOutData", obsData, 0);
      sel = 1'b1;
      #1;
      checkOutput("rstSmallReady", obsReady, 1);
      checkOutput("rstSmallBusy", obsBusy, 0);
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // Write then dump.
      doWrite(3, 5);
      doDump(-1, 1'b0, -1, -1, ab);

      // Back-to-back writes with cmd_valid held.
      waitReady();
      applyStimulus(1'b1, 1'b0, 1, 10);
      tick();
      checkOutput("b2bWe1", obsWe, 1);
      checkOutput("b2bWa1", obsWa, 1);
      checkOutput("b2bWd1", obsWd, 10);
      checkOutput("b2bReadyLow", obsReady, 0);
      applyStimulus(1'b1, 1'b0, 7, 15);
      tick();
      checkOutput("b2bGapWe", obsWe, 0);
      checkOutput("b2bGapReady", obsReady, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("b2bWe2", obsWe, 1);
      checkOutput("b2bWa2", obsWa, 7);
      checkOutput("b2bWd2", obsWd, 15);
      expM[1] = 4'hA;
      expM[7] = 4'hF;
      tick();
      checkOutput("b2bWeDrop", obsWe, 0);

      // Backpressure at address 2.
      doDump(2, 1'b0, -1, -1, ab);

      // Write command presented while a dump is at address 1.
      doDump(-1, 1'b0, 1, -1, ab);
      checkOutput("rejReadyIdle", obsReady, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("rejWe", obsWe, 1);
      checkOutput("rejWa", obsWa, 4);
      checkOutput("rejWd", obsWd, 3);
      expM[4] = 4'h3;
      tick();
      doDump(-1, 1'b0, -1, -1, ab);

      // Random writes, then a dump under random backpressure.
      repeat (12) doWrite(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      doDump(-1, 1'b1, -1, -1, ab);

      // Reset right after the handshake for address 4.
      doDump(-1, 1'b0, -1, 4, ab);
      checkOutput("abortReached", 32'(ab), 1);
      rst = 1'b1;
      #1;
      checkOutput("midRstValid", obsValid, 0);
      checkOutput("midRstBusy", obsBusy, 0);
      checkOutput("midRstWe", obsWe, 0);
      checkOutput("midRstReady", obsReady, 1);
      checkOutput("midRstRa", obsRa, 0);
      tick();
      rst = 1'b0;
      outReady = 1'b1;
      cnt = 0;
      repeat (20) begin
         tick();
         if (obsValid != 0) cnt++;
      end
      outReady = 1'b0;
      checkOutput("noWordsAfterRst", 32'(cnt), 0);
      checkOutput("idleAfterRst", obsBusy, 0);
      doDump(-1, 1'b0, -1, -1, ab);

      // Narrow instance: 4 words, last address 3.
      sel = 1'b1;
      #1;
      doWrite(3, 9);
      doWrite(0, int'($urandom_range(0, 15)));
      doDump(-1, 1'b0, -1, -1, ab);
      doWrite(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      doDump(-1, 1'b1, -1, -1, ab);
      sel = 1'b0;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Sequential master for the register file's write port and debug read port (ra2/rd2). Accepts single-register write commands and full-dump commands over a valid/ready command interface. A dump scans every register address in order and streams (address, data) pairs out over a valid/ready output interface. Sits between the switch/button front end (or a debug host) and the register file.

Parameters:
DATA_W, 4, register data width; must equal the register file data width.
ADDR_N, 3, register address width; the register file holds 2**ADDR_N entries.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_op  in  1  0 = write register, 1 = dump all registers.
cmd_addr  in  ADDR_N  target address for a write.
cmd_data  in  DATA_W  write data.
rf_wa  out  ADDR_N  register file write address.
rf_wd  out  DATA_W  register file write data.
rf_we  out  1  register file write enable.
rf_ra  out  ADDR_N  register file debug read address.
rf_rd  in  DATA_W  register file debug read data; combinational from rf_ra.
out_valid  out  1  dump word present.
out_ready  in  1  consumer accepts the dump word.
out_addr  out  ADDR_N  address of the dumped word.
out_data  out  DATA_W  dumped register value.
busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset: state = IDLE. rf_we, out_valid and busy are 0. rf_wa, rf_wd, rf_ra, out_addr, out_data and the scan index are all 0. cmd_ready is 1.
- All outputs are registered, except cmd_ready and busy, which decode the state.
- States: IDLE, WRITE, SCAN, OUT.
- IDLE:
  - cmd_ready = 1.
  - cmd_valid & cmd_op=0: latch rf_wa <= cmd_addr and rf_wd <= cmd_data, set rf_we <= 1, go to WRITE.
  - cmd_valid & cmd_op=1: idx <= 0, rf_ra <= 0, go to SCAN.
- WRITE:
  - rf_we is high for exactly one clock period. The register file commits the write on the falling edge inside this period.
  - Next posedge: rf_we <= 0, go to IDLE.
  - Write latency: one command handshake, then one cycle of rf_we, then ready again. A back-to-back write can be accepted every 2 cycles.
  - Any address, including 0, is writable.
- SCAN:
  - rf_ra = idx is stable for the full cycle.
  - Next posedge: out_data <= rf_rd, out_addr <= idx, out_valid <= 1, go to OUT.
- OUT:
  - Hold out_valid, out_addr and out_data stable until out_ready=1. Backpressure of any length is legal.
  - On handshake with idx = 2**ADDR_N-1: out_valid <= 0, go to IDLE.
  - On handshake otherwise: out_valid <= 0, idx <= idx+1, rf_ra <= idx+1, go to SCAN.
  - Dump throughput: one word per 2 cycles when out_ready is held high.
  - A full dump takes exactly 2**ADDR_N words, addresses 0 through 2**ADDR_N-1 ascending, with no wrap or repeat.
- rf_we is never asserted in SCAN or OUT. Dump data is therefore never affected by write forwarding.
- cmd_ready = 0 in WRITE, SCAN and OUT. Commands presented while busy are not accepted and not queued; the source must hold them.
- The scan index is ADDR_N+1 bits internally, so the last-address compare does not overflow.
- Reset asserted mid-write or mid-dump: immediate return to the reset values. A partial dump is abandoned, and no further out_valid appears until a new dump command.

Test Plan:
- Write, then dump: write 0x5 to address 3, dump with out_ready=1. Required: rf_we high for exactly 1 cycle with rf_wa=3, rf_wd=5. Dump emits 8 words, addresses 0..7, and word 3 = 0x5.
- Back-to-back writes: 0xA to address 1, then 0xF to address 7, cmd_valid held. Required: cmd_ready low during WRITE, second write accepted 2 cycles after the first, and the dump shows address 1 = 0xA and address 7 = 0xF.
- Backpressure: during a dump, hold out_ready=0 for 5 cycles at address 2. Required: out_valid, out_addr=2 and out_data held constant, idx not advanced, and the dump completes with exactly 8 words and no duplicates.
- Busy rejection: assert a write command (address 4, data 0x3) while a dump is at address 1. Required: not accepted until IDLE, then the write executes and a later dump shows address 4 = 0x3.
- Reset mid-dump: assert rst after the handshake for address 4. Required: out_valid, busy and rf_we go to 0 immediately, cmd_ready goes to 1, and no words are emitted after rst is released.
- Boundary with ADDR_N=2: dump with out_ready=1. Required: exactly 4 words, last address 3, busy deasserts on the cycle after the final handshake.
